// File: rtl/bp_nonsynth_commit_trace_arbiter.sv
// Merges per-core commit records into a single trace stream through per-core FIFOs,
// a round-robin arbiter and a one-entry output stage. Define BP_COMMIT_TRACE_ARB_FIXED_PRIO_EN
// to replace round-robin with fixed lowest-index-first priority.
module bp_nonsynth_commit_trace_arbiter #(
    parameter int num_core_p    = 2,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int dword_width_p = 64,
    parameter int els_p         = 8,
    localparam int core_w_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_core_p-1:0]                  commit_v_i,
    input  logic [2*num_core_p-1:0]                commit_priv_i,
    input  logic [vaddr_width_p*num_core_p-1:0]    commit_pc_i,
    input  logic [instr_width_p*num_core_p-1:0]    commit_instr_i,
    input  logic [num_core_p-1:0]                  commit_rd_w_v_i,
    input  logic [5*num_core_p-1:0]                commit_rd_addr_i,
    input  logic [dword_width_p*num_core_p-1:0]    commit_rd_data_i,
    output logic [num_core_p-1:0]                  commit_ready_o,
    output logic                                   trace_v_o,
    output logic [core_w_lp-1:0]                   trace_core_o,
    output logic [1:0]                             trace_priv_o,
    output logic [vaddr_width_p-1:0]               trace_pc_o,
    output logic [instr_width_p-1:0]               trace_instr_o,
    output logic                                   trace_rd_w_v_o,
    output logic [4:0]                             trace_rd_addr_o,
    output logic [dword_width_p-1:0]               trace_rd_data_o,
    output logic [31:0]                            trace_seq_o,
    input  logic                                   trace_yumi_i,
    output logic [16*num_core_p-1:0]               drop_cnt_o
);

    localparam int aw_lp  = $clog2(els_p);
    localparam int pad_lp = 1 << core_w_lp;
    localparam logic [aw_lp:0] full_lp = (aw_lp+1)'(els_p);

    typedef struct packed {
        logic [1:0]               priv;
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic                     rd_w_v;
        logic [4:0]               rd_addr;
        logic [dword_width_p-1:0] rd_data;
    } rec_s;

    // Handshakes: a commit is taken when commit_v_i & commit_ready_o at a rising edge;
    // the output record is consumed when trace_v_o & trace_yumi_i at a rising edge, and
    // trace_* hold steady while trace_v_o=1 and trace_yumi_i=0.
    logic [num_core_p-1:0] enq;
    logic [num_core_p-1:0] deq;
    logic [num_core_p-1:0] nonempty;
    logic [pad_lp-1:0]     nonempty_pad;
    rec_s                  head_rec [pad_lp];

    logic                  load_en;
    logic                  grant_v;
    logic [core_w_lp-1:0]  grant_idx;
    logic [core_w_lp-1:0]  scan_base;
    logic [core_w_lp-1:0]  cand;

    logic                  trace_v_q;
    logic [core_w_lp-1:0]  trace_core_q;
    rec_s                  trace_rec_q;
    logic [31:0]           seq_q;

    assign load_en      = ~trace_v_q | trace_yumi_i;
    assign nonempty_pad = pad_lp'(nonempty);

    for (genvar c = 0; c < num_core_p; c++) begin : g_core
        rec_s             mem [els_p];
        rec_s             in_rec;
        logic [aw_lp-1:0] wr_ptr_q;
        logic [aw_lp-1:0] rd_ptr_q;
        logic [aw_lp:0]   cnt_q;
        logic [15:0]      drop_q;

        assign in_rec.priv    = commit_priv_i[2*c +: 2];
        assign in_rec.pc      = commit_pc_i[vaddr_width_p*c +: vaddr_width_p];
        assign in_rec.instr   = commit_instr_i[instr_width_p*c +: instr_width_p];
        assign in_rec.rd_w_v  = commit_rd_w_v_i[c];
        assign in_rec.rd_addr = commit_rd_addr_i[5*c +: 5];
        assign in_rec.rd_data = commit_rd_data_i[dword_width_p*c +: dword_width_p];

        // Ready comes only from the registered count, so a full FIFO refuses a commit even
        // in a cycle where it is also being dequeued.
        assign commit_ready_o[c] = (cnt_q != full_lp);
        assign nonempty[c]       = (cnt_q != '0);
        assign enq[c]            = commit_v_i[c] & commit_ready_o[c];
        assign deq[c]            = load_en & grant_v & (grant_idx == core_w_lp'(c));
        assign head_rec[c]       = mem[rd_ptr_q];
        assign drop_cnt_o[16*c +: 16] = drop_q;

        always_ff @(posedge clk_i) begin
            if (enq[c]) begin
                mem[wr_ptr_q] <= in_rec;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                drop_q   <= '0;
            end else begin
                if (enq[c]) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (deq[c]) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (enq[c] & ~deq[c]) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (~enq[c] & deq[c]) begin
                    cnt_q <= cnt_q - 1'b1;
                end
                if (commit_v_i[c] & ~commit_ready_o[c] & (drop_q != 16'hFFFF)) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    for (genvar c = num_core_p; c < pad_lp; c++) begin : g_pad
        assign head_rec[c] = '0;
    end

`ifdef BP_COMMIT_TRACE_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [core_w_lp-1:0] rr_ptr_q;

    assign scan_base = rr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_ptr_q <= '0;
        end else if (load_en & grant_v) begin
            rr_ptr_q <= (grant_idx == core_w_lp'(num_core_p-1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Scan from the farthest offset down so the candidate nearest scan_base wins.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = num_core_p-1; i >= 0; i--) begin
            if (int'(scan_base) + i >= num_core_p) begin
                cand = core_w_lp'(int'(scan_base) + i - num_core_p);
            end else begin
                cand = core_w_lp'(int'(scan_base) + i);
            end
            if (nonempty_pad[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            trace_v_q    <= 1'b0;
            trace_core_q <= '0;
            trace_rec_q  <= '0;
            seq_q        <= '0;
        end else begin
            if (trace_v_q & trace_yumi_i) begin
                seq_q <= seq_q + 32'd1;
            end
            if (load_en) begin
                trace_v_q <= grant_v;
                if (grant_v) begin
                    trace_rec_q  <= head_rec[grant_idx];
                    trace_core_q <= grant_idx;
                end
            end
        end
    end

    assign trace_v_o       = trace_v_q;
    assign trace_core_o    = trace_core_q;
    assign trace_priv_o    = trace_rec_q.priv;
    assign trace_pc_o      = trace_rec_q.pc;
    assign trace_instr_o   = trace_rec_q.instr;
    assign trace_rd_w_v_o  = trace_rec_q.rd_w_v;
    assign trace_rd_addr_o = trace_rec_q.rd_addr;
    assign trace_rd_data_o = trace_rec_q.rd_data;
    assign trace_seq_o     = seq_q;

endmodule
